// File: rtl/ps2_key_ctrl.sv
// PS/2 scancode sequencer: pops receiver bytes, tracks make/break/E0 prefixes.
// Optional shift-aware case conversion: define PS2_KEY_CTRL_SHIFT_EN.
module ps2_key_ctrl #(
  parameter int         CNT_W    = 8,
  parameter logic [7:0] BRK_CODE = 8'hF0,
  parameter logic [7:0] EXT_CODE = 8'hE0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ps2_ready,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_overflow,
  output logic             ps2_nextdata_n,
  output logic [7:0]       rom_addr,
  input  logic [7:0]       rom_q,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic             key_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_ovf
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] POP    = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic             popn_q, popn_d;
  logic [7:0]       code_q, code_d;
  logic             kext_q, kext_d;
  logic             down_q, down_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ascii_q, ascii_d;
  logic             ovf_q, ovf_d;
  logic             same_key;

`ifdef PS2_KEY_CTRL_SHIFT_EN
  logic shift_q, shift_d;
  logic shift_key;
  assign shift_key = (byte_q == 8'h12 || byte_q == 8'h59) && !ext_q;
`endif

  assign same_key = down_q && (byte_q == code_q) && (ext_q == kext_q);

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    popn_d  = popn_q;
    code_d  = code_q;
    kext_d  = kext_q;
    down_d  = down_q;
    cnt_d   = cnt_q;
`ifdef PS2_KEY_CTRL_SHIFT_EN
    shift_d = shift_q;
`endif
    case (state_q)
      IDLE: begin
        if (ps2_ready) begin
          byte_d  = ps2_data;
          popn_d  = 1'b0;
          state_d = POP;
        end
      end
      POP: begin
        popn_d  = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        if (byte_q == BRK_CODE) begin
          brk_d = 1'b1;
        end else if (byte_q == EXT_CODE) begin
          ext_d = 1'b1;
        end else if (brk_q) begin
`ifdef PS2_KEY_CTRL_SHIFT_EN
          if (shift_key) shift_d = 1'b0;
          else
`endif
          if (same_key) down_d = 1'b0;
          brk_d = 1'b0;
          ext_d = 1'b0;
`ifdef PS2_KEY_CTRL_SHIFT_EN
        end else if (shift_key) begin
          shift_d = 1'b1;
          ext_d   = 1'b0;
`endif
        end else if (same_key) begin
          ext_d = 1'b0;
        end else begin
          code_d = byte_q;
          kext_d = ext_q;
          down_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          ext_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ASCII tracks the ROM every cycle; extended keys have no printable code
  always_comb begin
    ascii_d = kext_q ? 8'h00 : rom_q;
`ifdef PS2_KEY_CTRL_SHIFT_EN
    if (!kext_q && shift_q && rom_q >= 8'h61 && rom_q <= 8'h7A)
      ascii_d = rom_q - 8'h20;
`endif
    ovf_d = ovf_q | ps2_overflow;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      byte_q  <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      popn_q  <= 1'b1;
      code_q  <= '0;
      kext_q  <= 1'b0;
      down_q  <= 1'b0;
      cnt_q   <= '0;
      ascii_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      popn_q  <= popn_d;
      code_q  <= code_d;
      kext_q  <= kext_d;
      down_q  <= down_d;
      cnt_q   <= cnt_d;
      ascii_q <= ascii_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef PS2_KEY_CTRL_SHIFT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) shift_q <= 1'b0;
    else         shift_q <= shift_d;
  end
`endif

  assign ps2_nextdata_n = popn_q;
  assign rom_addr       = code_q;
  assign key_code       = code_q;
  assign key_ascii      = ascii_q;
  assign key_down       = down_q;
  assign key_ext        = kext_q;
  assign press_cnt      = cnt_q;
  assign err_ovf        = ovf_q;

endmodule
